// File: rtl/mux8way16_rr.sv
// mux8way16_rr: registered 8-to-1 merge of 16-bit lanes with round-robin
// arbitration, per-lane burst limit and valid/ready handshakes on both sides.
// Each output word is tagged with its source lane index in out_sel.
// Build option: MUX8WAY16_RR_ZERO_IDLE_EN clears out/out_sel on idle load cycles;
// without it an idle output keeps the last delivered word.
module mux8way16_rr #(
  parameter int unsigned width = 16,
  parameter int unsigned burst = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  input  logic [width-1:0] in3,
  input  logic [width-1:0] in4,
  input  logic [width-1:0] in5,
  input  logic [width-1:0] in6,
  input  logic [width-1:0] in7,
  input  logic [width-1:0] in8,
  input  logic [7:0]       in_valid,
  output logic [7:0]       in_ready,
  output logic [width-1:0] out,
  output logic [2:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [3:0] burst_m1 = 4'(burst - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic [width-1:0] lane [8];
  logic [2:0]       last;
  logic [2:0]       last_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             grant;
  logic [2:0]       gidx;
  logic [7:0]       gnt_vec;
  logic [2:0]       cand;

  assign lane[0] = in1;
  assign lane[1] = in2;
  assign lane[2] = in3;
  assign lane[3] = in4;
  assign lane[4] = in5;
  assign lane[5] = in6;
  assign lane[6] = in7;
  assign lane[7] = in8;

  // The output register can take a new word when empty or being drained.
  assign load = (state == EMPTY) || out_ready;

  // Round-robin grant with burst limit; search starts after last and ends at last.
  always_comb begin
    grant    = 1'b0;
    gidx     = last;
    last_nxt = last;
    cnt_nxt  = cnt;
    cand     = '0;
    if (load) begin
      if (in_valid[last] && (cnt < burst_m1)) begin
        grant   = 1'b1;
        gidx    = last;
        cnt_nxt = cnt + 4'd1;
      end else begin
        for (int unsigned k = 1; k <= 8; k++) begin
          cand = last + 3'(k);
          if (!grant && in_valid[cand]) begin
            grant = 1'b1;
            gidx  = cand;
          end
        end
        if (grant) begin
          last_nxt = gidx;
          cnt_nxt  = '0;
        end
      end
    end
  end

  // One-hot accept strobe, suppressed while reset is held.
  always_comb begin
    gnt_vec       = '0;
    gnt_vec[gidx] = grant;
    in_ready      = reset ? '0 : gnt_vec;
  end

  // Next output-register state: any load cycle refills or empties it.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = grant ? FULL : EMPTY;
    end
  end

  assign out_valid = (state == FULL);

  // State, arbitration history and output word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      last    <= 3'd7;
      cnt     <= burst_m1;
      out     <= '0;
      out_sel <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        out     <= lane[gidx];
        out_sel <= gidx;
      end
`ifdef MUX8WAY16_RR_ZERO_IDLE_EN
      else if (load) begin
        out     <= '0;
        out_sel <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux8way16_rr.sv
// Directed testbench for mux8way16_rr: burst=4 instance (dut) and burst=1
// instance (dut1) share the same lane stimulus.
module tb_mux8way16_rr;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in1, in2, in3, in4, in5, in6, in7, in8;
  logic [7:0]  in_valid;
  logic        out_ready;
  logic [7:0]  in_ready, in_ready1;
  logic [15:0] out, out1;
  logic [2:0]  out_sel, out_sel1;
  logic        out_valid, out_valid1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux8way16_rr #(.width(16), .burst(4)) dut (
    .clk(clk), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux8way16_rr #(.width(16), .burst(1)) dut1 (
    .clk(clk), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .in_valid(in_valid), .in_ready(in_ready1),
    .out(out1), .out_sel(out_sel1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes_index();
    in1 = 16'd1; in2 = 16'd2; in3 = 16'd3; in4 = 16'd4;
    in5 = 16'd5; in6 = 16'd6; in7 = 16'd7; in8 = 16'd8;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    lanes_index();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 8'h00) begin
      miscompares++; $display("FAIL reset_in_ready got=%h exp=00", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0 || out_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_out got v=%b out=%h sel=%0d exp v=0 out=0000 sel=0", out_valid, out, out_sel);
    end
    in_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_lane();
    do_reset();
    in3 = 16'h1234;
    in_valid = 8'b0000_0100;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'b0000_0100) begin
      miscompares++; $display("FAIL single_in_ready got=%b exp=00000100", in_ready);
    end
    tick();
    in_valid = '0;
    vectors++;
    if (out !== 16'h1234 || out_sel !== 3'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_out got out=%h sel=%0d v=%b exp out=1234 sel=2 v=1", out, out_sel, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_drain got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  es4, es1;
    do_reset();
    lanes_index();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h01 || in_ready1 !== 8'h01) begin
      miscompares++; $display("FAIL rr_first_grant got=%h/%h exp=01/01", in_ready, in_ready1);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      es4 = 3'((k - 1) / 4);
      es1 = 3'((k - 1) % 8);
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== es4 || out !== {13'd0, es4} + 16'd1) begin
        miscompares++;
        $display("FAIL rr_burst4 k=%0d got sel=%0d out=%0d v=%b exp sel=%0d out=%0d v=1",
                 k, out_sel, out, out_valid, es4, es4 + 1);
      end
      vectors++;
      if (out_valid1 !== 1'b1 || out_sel1 !== es1 || out1 !== {13'd0, es1} + 16'd1) begin
        miscompares++;
        $display("FAIL rr_burst1 k=%0d got sel=%0d out=%0d v=%b exp sel=%0d out=%0d v=1",
                 k, out_sel1, out1, out_valid1, es1, es1 + 1);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    lanes_index();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (in_ready !== 8'h00 || in_ready1 !== 8'h00) begin
        miscompares++; $display("FAIL bp_in_ready k=%0d got=%h/%h exp=00/00", k, in_ready, in_ready1);
      end
      vectors++;
      if (out_sel !== 3'd0 || out !== 16'd1 || out_valid !== 1'b1 ||
          out_sel1 !== 3'd1 || out1 !== 16'd2 || out_valid1 !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold k=%0d got sel=%0d/%0d out=%0d/%0d exp sel=0/1 out=1/2",
                 k, out_sel, out_sel1, out, out1);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h01 || in_ready1 !== 8'h04) begin
      miscompares++; $display("FAIL bp_resume_ready got=%h/%h exp=01/04", in_ready, in_ready1);
    end
    tick();
    vectors++;
    if (out_sel !== 3'd0 || out_sel1 !== 3'd2 || out1 !== 16'd3) begin
      miscompares++; $display("FAIL bp_resume1 got sel=%0d/%0d exp sel=0/2", out_sel, out_sel1);
    end
    tick();
    vectors++;
    if (out_sel !== 3'd0) begin
      miscompares++; $display("FAIL bp_resume2 got sel=%0d exp sel=0", out_sel);
    end
    tick();
    vectors++;
    if (out_sel !== 3'd1 || out !== 16'd2) begin
      miscompares++; $display("FAIL bp_resume3 got sel=%0d out=%0d exp sel=1 out=2", out_sel, out);
    end
    in_valid = '0;
  endtask

  task automatic test_wrap_lane7();
    do_reset();
    in8 = 16'h7777;
    in_valid = 8'h80;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h80 || in_ready1 !== 8'h80) begin
      miscompares++; $display("FAIL wrap_in_ready got=%h/%h exp=80/80", in_ready, in_ready1);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (out_sel !== 3'd7 || out !== 16'h7777 || out_valid !== 1'b1 ||
          out_sel1 !== 3'd7 || out_valid1 !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_lane7 k=%0d got sel=%0d/%0d out=%h v=%b/%b exp sel=7/7 out=7777 v=1/1",
                 k, out_sel, out_sel1, out, out_valid, out_valid1);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in1 = 16'hBEEF;
    in_valid = 8'h01;
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    out_ready = 1'b0;
    vectors++;
    if (out !== 16'hBEEF || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_loaded got out=%h v=%b exp out=BEEF v=1", out, out_valid);
    end
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0 || out_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_async got v=%b out=%h sel=%0d exp v=0 out=0000 sel=0", out_valid, out, out_sel);
    end
    #2;
    reset = 1'b0;
    lanes_index();
    in_valid = 8'hFF;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h01) begin
      miscompares++; $display("FAIL mid_regrant got=%h exp=01", in_ready);
    end
    tick();
    vectors++;
    if (out_sel !== 3'd0 || out !== 16'd1 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_first got sel=%0d out=%0d v=%b exp sel=0 out=1 v=1", out_sel, out, out_valid);
    end
    in_valid = '0;
  endtask

  task automatic test_idle();
    logic [15:0] exp_out;
    logic [2:0]  exp_sel;
    do_reset();
    in5 = 16'h5555;
    in_valid = 8'h10;
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    vectors++;
    if (out !== 16'h5555 || out_sel !== 3'd4 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL idle_load got out=%h sel=%0d v=%b exp out=5555 sel=4 v=1", out, out_sel, out_valid);
    end
    tick();
`ifdef MUX8WAY16_RR_ZERO_IDLE_EN
    exp_out = 16'h0000;
    exp_sel = 3'd0;
`else
    exp_out = 16'h5555;
    exp_sel = 3'd4;
`endif
    vectors++;
    if (out_valid !== 1'b0 || out !== exp_out || out_sel !== exp_sel) begin
      miscompares++;
      $display("FAIL idle_out got v=%b out=%h sel=%0d exp v=0 out=%h sel=%0d", out_valid, out, out_sel, exp_out, exp_sel);
    end
  endtask

  initial begin
    lanes_index();
    in_valid = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_wrap_lane7();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
